// File: rtl/uart_rx_fifo.sv
// UART receive path: oversampled majority-vote receiver with parity, 1/2 stop bits and
// break detection, feeding a first-word-fall-through FIFO with sticky overflow and RTS.
module uart_rx_fifo #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int RTS_THRESH  = FIFO_DEPTH - 2
) (
    input  logic                          SysClk,
    input  logic                          Rst_n,
    input  logic                          Rx,
    input  logic                          Read_Done,
    input  logic                          Overflow_Clr,
    output logic [DATA_BITS-1:0]          Data_Out,
    output logic [2:0]                    Rx_Error,
    output logic                          Data_Rdy,
    output logic                          FIFO_Empty,
    output logic                          FIFO_Full,
    output logic                          FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count,
    output logic                          RTS,
    output logic                          Rx_Busy
);

    localparam int BAUD_X  = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_RAW = (SYSCLK_RATE + BAUD_X / 2) / BAUD_X;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = DATA_BITS + 3;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_RES   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THRESH_C  = CW'(RTS_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [TW-1:0]        r_tick_cnt;
    state_t               r_state;
    state_t               w_state_next;
    logic [SW-1:0]        r_smp_cnt;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_all_zero;

    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic                 r_rts;

    logic                 w_tick;
    logic                 w_fall;
    logic                 w_res;
    logic                 w_end;
    logic                 w_bit;
    logic                 w_brk;
    logic                 w_start;
    logic                 w_push;
    logic                 w_shift;
    logic                 w_bit_inc;
    logic                 w_par_res;
    logic                 w_stop_res;
    logic                 w_stop_inc;
    logic [2:0]           w_push_err;
    logic [EW-1:0]        w_push_word;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push_ok;
    logic [EW-1:0]        w_head;

    // NOTE: every sequential block uses non-blocking assignments so all flops update
    // together from pre-edge values, independent of block evaluation order.
    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_fall = r_rx_prev & ~r_rx_s;
    assign w_res  = w_tick && (r_smp_cnt == SMP_RES);
    assign w_end  = w_tick && (r_smp_cnt == SMP_LAST);
    assign w_bit  = (r_samp_a & r_samp_b) | (r_samp_a & r_rx_s) | (r_samp_b & r_rx_s);
    assign w_brk  = r_all_zero & ~w_bit;

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_start || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_push       = 1'b0;
        w_shift      = 1'b0;
        w_bit_inc    = 1'b0;
        w_par_res    = 1'b0;
        w_stop_res   = 1'b0;
        w_stop_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_start      = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_res && w_bit) begin
                    w_state_next = S_IDLE;
                end else if (w_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_shift = w_res;
                if (w_end) begin
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_par_res = w_res;
                if (w_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                w_stop_res = w_res;
                if (w_res && (r_stop_idx == STOP_LAST)) begin
                    w_push       = 1'b1;
                    w_state_next = w_brk ? S_BREAK_WAIT : S_IDLE;
                end else if (w_end) begin
                    w_stop_inc = 1'b1;
                end
            end
            S_BREAK_WAIT: begin
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_smp_cnt  <= '0;
            r_samp_a   <= 1'b1;
            r_samp_b   <= 1'b1;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_all_zero <= 1'b1;
        end else if (w_start) begin
            r_smp_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_all_zero <= 1'b1;
        end else begin
            if (w_tick) begin
                r_smp_cnt <= (r_smp_cnt == SMP_LAST) ? '0 : r_smp_cnt + SW'(1);
                if (r_smp_cnt == SMP_A) r_samp_a <= r_rx_s;
                if (r_smp_cnt == SMP_B) r_samp_b <= r_rx_s;
            end
            if (w_shift) begin
                r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            end
            if (w_bit_inc) begin
                r_bit_idx <= r_bit_idx + BW'(1);
            end
            if (w_par_res) begin
                r_par_err <= ((^r_shift) ^ w_bit) != (PARITY_MODE == 2);
            end
            if (w_stop_res && !w_bit) begin
                r_frm_err <= 1'b1;
            end
            if ((w_shift || w_par_res || w_stop_res) && w_bit) begin
                r_all_zero <= 1'b0;
            end
            if (w_stop_inc) begin
                r_stop_idx <= 1'b1;
            end
        end
    end

    // A break overrides the parity result and always reports a framing error.
    assign w_push_err  = w_brk ? 3'b110 : {1'b0, r_frm_err | ~w_bit, r_par_err};
    assign w_push_word = {w_push_err, r_shift};

    assign w_full    = (r_count == DEPTH_C);
    assign w_pop     = Read_Done && (r_count != '0);
    assign w_push_ok = w_push && (!w_full || w_pop);

    // NOTE: the storage array has no reset; emptiness is tracked by the count, and the
    // outputs are gated while empty, so stale contents are never visible.
    always_ff @(posedge SysClk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_rts    <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (Overflow_Clr) begin
                r_ovf <= 1'b0;
            end
            r_rts <= (r_count < THRESH_C);
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign Data_Rdy      = (r_count != '0);
    assign FIFO_Empty    = (r_count == '0);
    assign FIFO_Full     = w_full;
    assign FIFO_Count    = r_count;
    assign FIFO_Overflow = r_ovf;
    assign RTS           = r_rts;
    assign Rx_Busy       = (r_state != S_IDLE);
    assign Data_Out      = Data_Rdy ? w_head[DATA_BITS-1:0] : '0;
    assign Rx_Error      = Data_Rdy ? w_head[EW-1:DATA_BITS] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames push expected words into a queue, and a
// monitor compares the head entry against it whenever a pop is presented.
module tb_uart_rx_fifo;

    localparam int BIT_CYC = 160;
    // Push edge counted from the edge after which the start bit is driven:
    // 3 edges of sync/edge detect, 11 full bits, then sample 9 of the last stop bit.
    localparam int PUSH_EDGE = 3 + 11 * BIT_CYC + 10 * (9 + 1);

    logic       SysClk       = 1'b0;
    logic       Rst_n        = 1'b1;
    logic       Rx           = 1'b1;
    logic       Read_Done    = 1'b0;
    logic       Overflow_Clr = 1'b0;
    logic [7:0] Data_Out;
    logic [2:0] Rx_Error;
    logic       Data_Rdy;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       FIFO_Overflow;
    logic [3:0] FIFO_Count;
    logic       RTS;
    logic       Rx_Busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;

    uart_rx_fifo #(
        .SYSCLK_RATE(1600000),
        .BAUD_RATE  (10000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .PARITY_MODE(1),
        .STOP_BITS  (2),
        .FIFO_DEPTH (8)
    ) dut (
        .SysClk       (SysClk),
        .Rst_n        (Rst_n),
        .Rx           (Rx),
        .Read_Done    (Read_Done),
        .Overflow_Clr (Overflow_Clr),
        .Data_Out     (Data_Out),
        .Rx_Error     (Rx_Error),
        .Data_Rdy     (Data_Rdy),
        .FIFO_Empty   (FIFO_Empty),
        .FIFO_Full    (FIFO_Full),
        .FIFO_Overflow(FIFO_Overflow),
        .FIFO_Count   (FIFO_Count),
        .RTS          (RTS),
        .Rx_Busy      (Rx_Busy)
    );

    always #5 SysClk = ~SysClk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge SysClk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] d, input logic [2:0] e);
        exp_q.push_back({e, d});
    endtask

    // Frame bits: start, 8 data LSB first, parity, stop1, stop2. glitch_bit < 0 means none.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1,
                              input logic s2, input int glitch_bit);
        logic [11:0] bits;
        bits = {s2, s1, par, d, 1'b0};
        tick(1);
        for (int j = 0; j < 12; j++) begin
            Rx = bits[j];
            if (j == glitch_bit) begin
                tick(90);
                Rx = ~bits[j];
                tick(1);
                Rx = bits[j];
                tick(BIT_CYC - 91);
            end else begin
                tick(BIT_CYC);
            end
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        expect_word(d, 3'b000);
        send_frame(d, ^d, 1'b1, 1'b1, -1);
    endtask

    // Same frame, with Read_Done held high exactly on the push edge.
    task automatic send_with_pop(input logic [7:0] d);
        fork
            send_frame(d, ^d, 1'b1, 1'b1, -1);
            begin
                tick(1);
                tick(PUSH_EDGE - 1);
                Read_Done = 1'b1;
                tick(1);
                Read_Done = 1'b0;
            end
        join
    endtask

    task automatic read_one();
        int w;
        w = 0;
        while (!Data_Rdy && w < 4000) begin
            tick(1);
            w++;
        end
        check("rdy_before_read", Data_Rdy, 1);
        if (Data_Rdy) begin
            Read_Done = 1'b1;
            tick(1);
            Read_Done = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data_out", Data_Out, 0);
        check("rst_rx_error", Rx_Error, 0);
        check("rst_count", FIFO_Count, 0);
        check("rst_data_rdy", Data_Rdy, 0);
        check("rst_empty", FIFO_Empty, 1);
        check("rst_full", FIFO_Full, 0);
        check("rst_overflow", FIFO_Overflow, 0);
        check("rst_busy", Rx_Busy, 0);
        check("rst_rts", RTS, 1);
    endtask

    always @(negedge SysClk) begin
        if (Read_Done && Data_Rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got data %0h err %b, required no entry", Data_Out, Rx_Error);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_data", Data_Out, mon_e[7:0]);
                check("pop_err", Rx_Error, mon_e[10:8]);
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        #1 Rst_n = 1'b0;
        tick(5);
        check_reset_outputs();
        Rst_n = 1'b1;
        tick(20);

        // Single word
        send_good(8'hA5);
        tick(20);
        check("single_rdy", Data_Rdy, 1);
        check("single_data", Data_Out, 8'hA5);
        check("single_err", Rx_Error, 3'b000);
        read_one();
        check("single_empty", FIFO_Empty, 1);

        // Error flags: parity, framing, break
        expect_word(8'h01, 3'b001);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, -1);
        tick(20);
        expect_word(8'h3C, 3'b010);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
        Rx = 1'b1;
        tick(20);
        expect_word(8'h00, 3'b110);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
        tick(5 * BIT_CYC);
        check("break_count_low", FIFO_Count, 3);
        check("break_busy_low", Rx_Busy, 1);
        Rx = 1'b1;
        tick(50);
        check("break_busy_high", Rx_Busy, 0);
        check("break_count_high", FIFO_Count, 3);
        repeat (3) read_one();
        check("err_empty", FIFO_Empty, 1);

        // Glitch rejection: short low pulse, then a data-bit glitch
        tick(1);
        Rx = 1'b0;
        tick(20);
        check("glitch_busy_start", Rx_Busy, 1);
        tick(20);
        Rx = 1'b1;
        tick(300);
        check("glitch_busy_end", Rx_Busy, 0);
        check("glitch_no_push", FIFO_Count, 0);
        expect_word(8'h96, 3'b000);
        send_frame(8'h96, 1'b0, 1'b1, 1'b1, 4);
        tick(20);
        read_one();

        // Fill and overflow
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                send_good(8'(i));
            end else begin
                send_frame(8'(i), ^(8'(i)), 1'b1, 1'b1, -1);
            end
            tick(10);
            if (i == 4) check("rts_after5", RTS, 1);
            if (i == 5) check("rts_after6", RTS, 0);
            if (i == 6) check("full_after7", FIFO_Full, 0);
            if (i == 7) check("full_after8", FIFO_Full, 1);
            if (i == 7) check("ovf_after8", FIFO_Overflow, 0);
            if (i == 8) check("ovf_after9", FIFO_Overflow, 1);
            if (i == 8) check("count_after9", FIFO_Count, 8);
        end
        Overflow_Clr = 1'b1;
        tick(1);
        Overflow_Clr = 1'b0;
        check("ovf_cleared", FIFO_Overflow, 0);

        // Push and pop on the same edge while full
        expect_word(8'h09, 3'b000);
        send_with_pop(8'h09);
        tick(10);
        check("simfull_count", FIFO_Count, 8);
        check("simfull_ovf", FIFO_Overflow, 0);
        check("simfull_full", FIFO_Full, 1);
        repeat (8) read_one();
        tick(2);
        check("drain_empty", FIFO_Empty, 1);
        check("drain_rts", RTS, 1);

        // Push and pop on the same edge while empty
        expect_word(8'h42, 3'b000);
        send_with_pop(8'h42);
        tick(10);
        check("simempty_count", FIFO_Count, 1);
        read_one();
        check("simempty_drained", FIFO_Empty, 1);

        // Reset in the middle of a frame with three words queued
        send_good(8'h11);
        send_good(8'h22);
        send_good(8'h33);
        tick(10);
        check("pre_rst_count", FIFO_Count, 3);
        tick(1);
        Rx = 1'b0;
        tick(BIT_CYC);
        Rx = 1'b1;
        tick(300);
        check("pre_rst_busy", Rx_Busy, 1);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        tick(10);
        Rst_n = 1'b1;
        tick(50);
        check("post_rst_busy", Rx_Busy, 0);
        check("post_rst_count", FIFO_Count, 0);
        send_good(8'h5A);
        tick(20);
        check("fresh_count", FIFO_Count, 1);
        read_one();
        check("fresh_empty", FIFO_Empty, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
